// File: rtl/filter_in.sv
// filter_in: AXI4-Stream ingress stage for the Sobel pipeline.
// Unpacks pixel words, buffers them through a two-entry skid buffer with a
// registered TREADY, and tags start-of-line / framing errors from a line counter.
module filter_in #(
    parameter int PIXEL       = 3,
    parameter int MEMORYWIDTH = 8,
    parameter int DATAWIDTH   = 32,
    parameter int LINE_WORDS  = 640
) (
    input  logic                         clk,
    input  logic                         ARESETN,
    input  logic [DATAWIDTH-1:0]         S_AXIS_TDATA,
    input  logic                         S_AXIS_TVALID,
    output logic                         S_AXIS_TREADY,
    input  logic                         S_AXIS_TLAST,
    output logic [MEMORYWIDTH*PIXEL-1:0] packed_pix,
    output logic                         o_strobe,
    input  logic                         i_busy,
    output logic                         out_tlast,
    output logic                         out_sol,
    output logic                         o_len_err
);

    localparam int PW = MEMORYWIDTH * PIXEL;
    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

    // Output register (presented word)
    logic [PW-1:0] outData_q, outData_d;
    logic          outLast_q, outLast_d;
    logic          outSol_q,  outSol_d;
    logic          outValid_q, outValid_d;

    // Skid register (word caught while the output is stalled)
    logic [PW-1:0] skData_q, skData_d;
    logic          skLast_q, skLast_d;
    logic          skSol_q,  skSol_d;
    logic          skValid_q, skValid_d;

    logic          ready_q, ready_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          lenErr_q, lenErr_d;

    logic [PW-1:0] inPix;
    logic          inSol;
    logic          accept;
    logic          outFree;
    logic          atLineEnd;
    logic          unusedBits;

    // Pixel k lives one byte-slot above its output position, so the whole
    // payload is one contiguous slice starting just past the dropped low byte.
    assign inPix      = S_AXIS_TDATA[MEMORYWIDTH +: PW];
    assign unusedBits = ^S_AXIS_TDATA;
    assign inSol      = (wcnt_q == '0);
    assign atLineEnd  = (wcnt_q == LAST_IDX);
    assign accept     = S_AXIS_TVALID && ready_q;
    assign outFree    = !outValid_q || !i_busy;

    // Next state: refill OUT from SK first (keeps order), otherwise from the
    // input; catch the input in SK when OUT is stalled; advance the line counter.
    always_comb begin
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        outSol_d   = outSol_q;
        outValid_d = outValid_q;
        skData_d   = skData_q;
        skLast_d   = skLast_q;
        skSol_d    = skSol_q;
        skValid_d  = skValid_q;
        wcnt_d     = wcnt_q;
        lenErr_d   = lenErr_q;

        if (outFree) begin
            if (skValid_q) begin
                outData_d  = skData_q;
                outLast_d  = skLast_q;
                outSol_d   = skSol_q;
                outValid_d = 1'b1;
                skValid_d  = 1'b0;
            end else if (accept) begin
                outData_d  = inPix;
                outLast_d  = S_AXIS_TLAST;
                outSol_d   = inSol;
                outValid_d = 1'b1;
            end else begin
                outValid_d = 1'b0;
            end
        end else if (accept) begin
            skData_d  = inPix;
            skLast_d  = S_AXIS_TLAST;
            skSol_d   = inSol;
            skValid_d = 1'b1;
        end

        if (accept) begin
            if (S_AXIS_TLAST || atLineEnd) begin
                wcnt_d = '0;
                if (S_AXIS_TLAST != atLineEnd) begin
                    lenErr_d = 1'b1;
                end
            end else begin
                wcnt_d = wcnt_q + CW'(1);
            end
        end

        ready_d = !skValid_d;
    end

    // State registers, cleared asynchronously while ARESETN is low
    always_ff @(posedge clk or negedge ARESETN) begin
        if (!ARESETN) begin
            outData_q  <= '0;
            outLast_q  <= 1'b0;
            outSol_q   <= 1'b0;
            outValid_q <= 1'b0;
            skData_q   <= '0;
            skLast_q   <= 1'b0;
            skSol_q    <= 1'b0;
            skValid_q  <= 1'b0;
            ready_q    <= 1'b0;
            wcnt_q     <= '0;
            lenErr_q   <= 1'b0;
        end else begin
            outData_q  <= outData_d;
            outLast_q  <= outLast_d;
            outSol_q   <= outSol_d;
            outValid_q <= outValid_d;
            skData_q   <= skData_d;
            skLast_q   <= skLast_d;
            skSol_q    <= skSol_d;
            skValid_q  <= skValid_d;
            ready_q    <= ready_d;
            wcnt_q     <= wcnt_d;
            lenErr_q   <= lenErr_d;
        end
    end

    assign S_AXIS_TREADY = ready_q;
    assign packed_pix    = outData_q;
    assign o_strobe      = outValid_q;
    assign out_tlast     = outLast_q;
    assign out_sol       = outSol_q;
    assign o_len_err     = lenErr_q;

endmodule
